traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Passive checker on the far side of the trafficLight output interface. Samples
//  LightA/LightB every clk, tracks the expected two-road phase sequence, and
//  flags illegal codes, conflicting greens, out-of-order steps and dwell-time
//  violations. Used in the bench and in the lab wrapper to drive LA status pins.
// PARAMETERS
//  GREEN_MIN   4   minimum green dwell, clk cycles
//  GREEN_MAX   8   maximum green dwell, clk cycles
//  YELLOW_LEN  2   exact yellow dwell, clk cycles
//  CNT_W       8   dwell counter width; must hold GREEN_MAX+1
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      async, active-low reset
//  LightA       in   3      road A light {R,Y,G}, one-hot
//  LightB       in   3      road B light {R,Y,G}, one-hot
//  phase        out  3      tracked phase (encoding in package)
//  err_code     out  1      pulse: a light is not one of 100/010/001
//  err_conflict out  1      pulse: neither road red
//  err_seq      out  1      pulse: legal but out-of-order transition
//  err_timing   out  1      pulse: dwell below min / above max / yellow != LEN
//  fault        out  1      sticky OR of all err_* until reset
//  cycles_done  out  16     count of complete AG->AY->BG->BY->AG rounds, wraps
// BEHAVIOUR
//  - Reset (reset=0): phase=SYNC, all err_*=0, fault=0, cycles_done=0,
//    dwell=0. Takes effect immediately, mid-phase included.
//  - Inputs are synchronous to clk. All outputs are registered; the flag for an
//    event sampled at edge N is visible after edge N+1 (1-cycle latency).
//  - Pattern decode: AG={A=001,B=100}, AY={A=010,B=100}, BG={A=100,B=001},
//    BY={A=100,B=010}. Any other one-hot pair with both red is ALLRED.
//  - Phase FSM: SYNC, AG, AY, BG, BY, FAULT_HOLD.
//    SYNC: wait for the first AG or BG, then enter it with dwell=1. No timing or
//    sequence check on the first partial phase seen from SYNC.
//    Legal steps: AG->AY->BG->BY->AG. A step where the pattern is unchanged
//    increments dwell, which saturates at 2^CNT_W-1.
//    Any other change -> err_seq, go to FAULT_HOLD.
//  - err_code/err_conflict take priority: on that cycle raise the flag, go to
//    FAULT_HOLD, and suppress err_seq/err_timing.
//  - FAULT_HOLD: re-enters SYNC on the first cycle after the pattern returns to
//    legal AG or BG. fault stays 1.
//  - Timing: dwell = cycles the current pattern has been held; it is 1 on the
//    first cycle.
//    On leaving G: err_timing if dwell<GREEN_MIN.
//    While in G: err_timing once, on the cycle dwell reaches GREEN_MAX+1.
//    On leaving Y: err_timing if dwell!=YELLOW_LEN.
//    A timing error does not change phase tracking.
//  - Simultaneous seq and timing errors on the same edge: both flags pulse.
//  - cycles_done increments on each legal BY->AG step reached from a full round
//    that started at AG; it wraps at 16 bits.
// STRUCTURE
//  - Package traffic_pkg: light codes LT_RED=3'b100, LT_YEL=3'b010,
//    LT_GRN=3'b001; phase encoding (SYNC=0, AG=1, AY=2, BG=3, BY=4,
//    FAULT_HOLD=5).
//  - Sub-module phase_timer: dwell counter with restart/saturate, plus min/max/
//    exact compare. Parameterised by CNT_W and takes its limits as inputs.
// TESTING  (defaults GREEN_MIN=4, GREEN_MAX=8, YELLOW_LEN=2, clk period 10)
//  1 reset=0 at t=25, high at t=55 with lights held AG.
//    -> all outputs 0 during reset; phase=AG 1 cycle after release.
//  2 Two legal rounds, G=5 and Y=2 cycles.
//    -> no err_*; cycles_done=1 after the second BY->AG step.
//  3 AG held 9 cycles.
//    -> err_timing pulses exactly once, 1 cycle after the 9th sample.
//    AY held 3 cycles -> a second err_timing on exit.
//  4 AG->BG directly.
//    -> err_seq=1 and fault=1, phase=FAULT_HOLD.
//    Then BG again -> phase=SYNC.
//  5 LightA=011 for 1 cycle.
//    -> err_code=1, err_seq=0.
//    A=001,B=001 -> err_conflict=1. fault stays 1 until reset.
//  6 reset pulsed low mid-BG.
//    -> fault, cycles_done and phase clear immediately; resync on the next AG
//       or BG pattern.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, tracked phase encoding and pattern helpers shared
// by the traffic light monitor and its dwell timer.
package traffic_pkg;

  // One-hot light codes, bit order {R,Y,G}
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // Tracked phase, visible on the monitor's phase output
  typedef enum logic [2:0] {
    SYNC       = 3'd0,
    AG         = 3'd1,
    AY         = 3'd2,
    BG         = 3'd3,
    BY         = 3'd4,
    FAULT_HOLD = 3'd5
  } phase_e;

  // What the two lights currently show, once decoded
  typedef enum logic [2:0] {
    PAT_AG     = 3'd0,
    PAT_AY     = 3'd1,
    PAT_BG     = 3'd2,
    PAT_BY     = 3'd3,
    PAT_ALLRED = 3'd4,
    PAT_OTHER  = 3'd5
  } pattern_e;

  // True when a single light shows exactly one lamp
  function automatic logic is_light_code(input logic [2:0] light);
    return (light == LT_RED) || (light == LT_YEL) || (light == LT_GRN);
  endfunction

  // Classify the pair of lights; anything that is not a named phase or
  // all-red lands in PAT_OTHER (code or conflict errors catch those)
  function automatic pattern_e decode_pattern(input logic [2:0] light_a,
                                              input logic [2:0] light_b);
    pattern_e pat;
    pat = PAT_OTHER;
    if (light_a == LT_GRN && light_b == LT_RED) pat = PAT_AG;
    else if (light_a == LT_YEL && light_b == LT_RED) pat = PAT_AY;
    else if (light_a == LT_RED && light_b == LT_GRN) pat = PAT_BG;
    else if (light_a == LT_RED && light_b == LT_YEL) pat = PAT_BY;
    else if (light_a == LT_RED && light_b == LT_RED) pat = PAT_ALLRED;
    return pat;
  endfunction

  // Pattern that a tracked phase expects to see on the lights
  function automatic pattern_e phase_pattern(input phase_e ph);
    pattern_e pat;
    case (ph)
      AG:      pat = PAT_AG;
      AY:      pat = PAT_AY;
      BG:      pat = PAT_BG;
      BY:      pat = PAT_BY;
      default: pat = PAT_OTHER;
    endcase
    return pat;
  endfunction

  // The only legal successor of each tracked phase
  function automatic phase_e next_legal(input phase_e ph);
    phase_e nxt;
    case (ph)
      AG:      nxt = AY;
      AY:      nxt = BG;
      BG:      nxt = BY;
      BY:      nxt = AG;
      default: nxt = SYNC;
    endcase
    return nxt;
  endfunction

  function automatic logic is_green(input phase_e ph);
    return (ph == AG) || (ph == BG);
  endfunction

  function automatic logic is_tracked(input phase_e ph);
    return (ph == AG) || (ph == AY) || (ph == BG) || (ph == BY);
  endfunction

endpackage

// File: rtl/traffic_light_monitor_phase_timer.sv
// phase_timer: counts how many cycles the current light pattern has been
// held and compares that dwell against the green/yellow limits.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             restart,
  input  logic [CNT_W-1:0] green_min,
  input  logic [CNT_W-1:0] green_max,
  input  logic [CNT_W-1:0] yellow_len,
  output logic             below_min,
  output logic             at_max,
  output logic             yellow_off
);

  localparam logic [CNT_W-1:0] DWELL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DWELL_SAT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] dwell;

  // Dwell: 0 outside tracked phases, 1 on a phase's first cycle, then counts up and sticks at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell <= '0;
    end else if (clear) begin
      dwell <= '0;
    end else if (restart) begin
      dwell <= DWELL_ONE;
    end else if (dwell != DWELL_SAT) begin
      dwell <= dwell + DWELL_ONE;
    end
  end

  // Compares on the dwell reached so far; at_max means the next held cycle crosses the green limit
  always_comb begin
    below_min  = dwell < green_min;
    at_max     = dwell == green_max;
    yellow_off = dwell != yellow_len;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the trafficLight outputs. Follows
// the AG->AY->BG->BY phase ring, pulses an error flag for bad codes, green
// conflicts, out-of-order steps and dwell violations, and keeps a sticky
// fault plus a count of completed rounds.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 8,
  parameter int YELLOW_LEN = 2,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  LightA,
  input  logic [2:0]  LightB,
  output logic [2:0]  phase,
  output logic        err_code,
  output logic        err_conflict,
  output logic        err_seq,
  output logic        err_timing,
  output logic        fault,
  output logic [15:0] cycles_done
);

  localparam logic [CNT_W-1:0] GREEN_MIN_C  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GREEN_MAX_C  = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YELLOW_LEN_C = CNT_W'(YELLOW_LEN);

  phase_e   state;
  phase_e   state_next;
  pattern_e pat;

  logic code_bad;
  logic conflict_bad;
  logic hard_err;
  logic tracking;
  logic same;
  logic legal_step;

  // partial_q: the phase was entered straight from SYNC, so its dwell is not
  // trusted. round_armed_q: AG was entered by a real BY->AG step, so the
  // next BY->AG closes a complete round.
  logic partial_q;
  logic partial_next;
  logic round_armed_q;
  logic round_armed_next;

  logic code_next;
  logic conflict_next;
  logic seq_next;
  logic timing_next;
  logic cycle_inc;

  logic timer_clear;
  logic timer_restart;
  logic below_min;
  logic at_max;
  logic yellow_off;

  assign pat          = decode_pattern(LightA, LightB);
  assign code_bad     = !is_light_code(LightA) || !is_light_code(LightB);
  assign conflict_bad = (LightA != LT_RED) && (LightB != LT_RED);
  assign hard_err     = code_bad || conflict_bad;
  assign tracking     = is_tracked(state);
  assign same         = pat == phase_pattern(state);
  assign legal_step   = pat == phase_pattern(next_legal(state));

  assign timer_clear   = (state_next == SYNC) || (state_next == FAULT_HOLD);
  assign timer_restart = state_next != state;

  assign phase = state;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (timer_clear),
    .restart    (timer_restart),
    .green_min  (GREEN_MIN_C),
    .green_max  (GREEN_MAX_C),
    .yellow_len (YELLOW_LEN_C),
    .below_min  (below_min),
    .at_max     (at_max),
    .yellow_off (yellow_off)
  );

  // Phase state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Next phase: bad codes or conflicts always park in FAULT_HOLD; otherwise follow the ring
  always_comb begin
    state_next = state;
    if (hard_err) begin
      state_next = FAULT_HOLD;
    end else begin
      case (state)
        SYNC: begin
          if (pat == PAT_AG) state_next = AG;
          else if (pat == PAT_BG) state_next = BG;
        end
        FAULT_HOLD: begin
          if (pat == PAT_AG || pat == PAT_BG) state_next = SYNC;
        end
        default: begin
          if (same) state_next = state;
          else if (legal_step) state_next = next_legal(state);
          else state_next = FAULT_HOLD;
        end
      endcase
    end
  end

  // Error flags and round count for this sample; seq and timing are ignored on a code/conflict cycle
  always_comb begin
    code_next     = code_bad;
    conflict_next = conflict_bad;
    seq_next      = 1'b0;
    timing_next   = 1'b0;
    cycle_inc     = 1'b0;
    if (!hard_err && tracking) begin
      if (is_green(state)) begin
        if (same) timing_next = !partial_q && at_max;
        else timing_next = !partial_q && below_min;
      end else if (!same) begin
        timing_next = yellow_off;
      end
      seq_next  = !same && !legal_step;
      cycle_inc = (state == BY) && legal_step && round_armed_q;
    end
  end

  // Bookkeeping for the partial first phase and round arming
  always_comb begin
    partial_next     = partial_q;
    round_armed_next = round_armed_q;
    if (!is_tracked(state_next)) begin
      partial_next = 1'b0;
    end else if (state == SYNC) begin
      partial_next = 1'b1;
    end else if (state_next != state) begin
      partial_next = 1'b0;
    end
    if (!is_tracked(state_next)) begin
      round_armed_next = 1'b0;
    end else if (state == BY && state_next == AG) begin
      round_armed_next = 1'b1;
    end
  end

  // Bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      partial_q     <= 1'b0;
      round_armed_q <= 1'b0;
    end else begin
      partial_q     <= partial_next;
      round_armed_q <= round_armed_next;
    end
  end

  // Registered error pulses, sticky fault and round counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_code     <= 1'b0;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
      err_timing   <= 1'b0;
      fault        <= 1'b0;
      cycles_done  <= 16'd0;
    end else begin
      err_code     <= code_next;
      err_conflict <= conflict_next;
      err_seq      <= seq_next;
      err_timing   <= timing_next;
      fault        <= fault | code_next | conflict_next | seq_next | timing_next;
      if (cycle_inc) cycles_done <= cycles_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scenarios followed by randomized light
// sequences, all compared cycle by cycle against a ring-position model.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  localparam int GREEN_MIN  = 4;
  localparam int GREEN_MAX  = 8;
  localparam int YELLOW_LEN = 2;
  localparam int CNT_W      = 8;

  localparam int M_SYNC  = 0;
  localparam int M_TRACK = 1;
  localparam int M_HOLD  = 2;

  logic        clk;
  logic        reset;
  logic [2:0]  LightA;
  logic [2:0]  LightB;
  logic [2:0]  phase;
  logic        errCode;
  logic        errConflict;
  logic        errSeq;
  logic        errTiming;
  logic        fault;
  logic [15:0] cyclesDone;

  int vectorCount;
  int missCount;

  // Ring of legal patterns: 0=AG 1=AY 2=BG 3=BY
  logic [2:0] ringA [4];
  logic [2:0] ringB [4];

  // Reference model: mode, ring position, cycles held, and expected outputs
  int          mMode;
  int          mPos;
  int          mHeld;
  bit          mFirst;
  bit          mArmed;
  logic [2:0]  expPhase;
  logic        expCode;
  logic        expConflict;
  logic        expSeq;
  logic        expTiming;
  logic        expFault;
  logic [15:0] expRounds;

  traffic_light_monitor #(
    .GREEN_MIN  (GREEN_MIN),
    .GREEN_MAX  (GREEN_MAX),
    .YELLOW_LEN (YELLOW_LEN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .LightA       (LightA),
    .LightB       (LightB),
    .phase        (phase),
    .err_code     (errCode),
    .err_conflict (errConflict),
    .err_seq      (errSeq),
    .err_timing   (errTiming),
    .fault        (fault),
    .cycles_done  (cyclesDone)
  );

  // Rising edges at 10, 20, ...; falling edges at 5, 15, ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not reach its summary");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit isLightCode(input logic [2:0] l);
    return (l == LT_RED) || (l == LT_YEL) || (l == LT_GRN);
  endfunction

  function automatic int ringIndex(input logic [2:0] a, input logic [2:0] b);
    for (int k = 0; k < 4; k++) begin
      if (ringA[k] == a && ringB[k] == b) return k;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mMode       = M_SYNC;
    mPos        = 0;
    mHeld       = 0;
    mFirst      = 1'b0;
    mArmed      = 1'b0;
    expPhase    = 3'd0;
    expCode     = 1'b0;
    expConflict = 1'b0;
    expSeq      = 1'b0;
    expTiming   = 1'b0;
    expFault    = 1'b0;
    expRounds   = 16'd0;
  endtask

  task automatic modelStep(input logic [2:0] a, input logic [2:0] b);
    int k;
    bit badCode;
    bit conflict;
    badCode     = !isLightCode(a) || !isLightCode(b);
    conflict    = (a != LT_RED) && (b != LT_RED);
    k           = ringIndex(a, b);
    expCode     = badCode;
    expConflict = conflict;
    expSeq      = 1'b0;
    expTiming   = 1'b0;
    if (badCode || conflict) begin
      mMode  = M_HOLD;
      mHeld  = 0;
      mArmed = 1'b0;
    end else if (mMode == M_SYNC) begin
      if (k == 0 || k == 2) begin
        mMode  = M_TRACK;
        mPos   = k;
        mHeld  = 1;
        mFirst = 1'b1;
      end
    end else if (mMode == M_HOLD) begin
      if (k == 0 || k == 2) mMode = M_SYNC;
    end else if (k == mPos) begin
      if (mHeld < 255) mHeld++;
      if (mPos % 2 == 0 && !mFirst && mHeld == GREEN_MAX + 1) expTiming = 1'b1;
    end else begin
      if (mPos % 2 == 0 && !mFirst && mHeld < GREEN_MIN) expTiming = 1'b1;
      if (mPos % 2 == 1 && mHeld != YELLOW_LEN) expTiming = 1'b1;
      if (k == (mPos + 1) % 4) begin
        if (mPos == 3) begin
          if (mArmed) expRounds = expRounds + 16'd1;
          mArmed = 1'b1;
        end
        mPos   = k;
        mHeld  = 1;
        mFirst = 1'b0;
      end else begin
        expSeq = 1'b1;
        mMode  = M_HOLD;
        mArmed = 1'b0;
      end
    end
    expFault = expFault | expCode | expConflict | expSeq | expTiming;
    if (mMode == M_SYNC) expPhase = 3'd0;
    else if (mMode == M_HOLD) expPhase = 3'd5;
    else expPhase = 3'(mPos + 1);
  endtask

  task automatic checkValue(input string name, input logic [15:0] observed,
                            input logic [15:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue($sformatf("%s.phase", tag), {13'd0, phase}, {13'd0, expPhase});
    checkValue($sformatf("%s.err_code", tag), {15'd0, errCode}, {15'd0, expCode});
    checkValue($sformatf("%s.err_conflict", tag), {15'd0, errConflict}, {15'd0, expConflict});
    checkValue($sformatf("%s.err_seq", tag), {15'd0, errSeq}, {15'd0, expSeq});
    checkValue($sformatf("%s.err_timing", tag), {15'd0, errTiming}, {15'd0, expTiming});
    checkValue($sformatf("%s.fault", tag), {15'd0, fault}, {15'd0, expFault});
    checkValue($sformatf("%s.cycles_done", tag), cyclesDone, expRounds);
  endtask

  // One cycle: drive at the falling edge, sample at the rising edge, check 1 time unit later
  task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input string tag);
    LightA = a;
    LightB = b;
    @(posedge clk);
    if (reset) modelStep(a, b);
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  task automatic holdPattern(input int idx, input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(ringA[idx], ringB[idx], tag);
  endtask

  // Reset pulse between edges; outputs must clear without waiting for a clock
  task automatic pulseReset(input string tag);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int cur;
    int len;
    int r;
    int k;
    ringA = '{LT_GRN, LT_YEL, LT_RED, LT_RED};
    ringB = '{LT_RED, LT_RED, LT_GRN, LT_YEL};
    vectorCount = 0;
    missCount   = 0;
    reset  = 1'b1;
    LightA = LT_GRN;
    LightB = LT_RED;
    modelReset();

    // 1: reset from t=25 to t=55 with AG held, then phase AG one cycle later
    #25;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("t1_in_reset");
    #20;
    checkOutput("t1_in_reset_late");
    #9;
    reset = 1'b1;
    applyStimulus(LT_GRN, LT_RED, "t1_release");
    checkValue("t1_phase_is_ag", {13'd0, phase}, 16'd1);

    // 2: two legal rounds, G=5 Y=2; only the second BY->AG counts
    holdPattern(0, 4, "t2");
    holdPattern(1, 2, "t2");
    holdPattern(2, 5, "t2");
    holdPattern(3, 2, "t2");
    holdPattern(0, 1, "t2");
    checkValue("t2_rounds_after_first", cyclesDone, 16'd0);
    holdPattern(0, 4, "t2");
    holdPattern(1, 2, "t2");
    holdPattern(2, 5, "t2");
    holdPattern(3, 2, "t2");
    holdPattern(0, 1, "t2");
    checkValue("t2_rounds_after_second", cyclesDone, 16'd1);
    checkValue("t2_no_fault", {15'd0, fault}, 16'd0);

    // 3: AG held 9 cycles, then AY held 3 cycles
    holdPattern(0, 7, "t3");
    checkValue("t3_dwell8_quiet", {15'd0, errTiming}, 16'd0);
    holdPattern(0, 1, "t3");
    checkValue("t3_dwell9_timing", {15'd0, errTiming}, 16'd1);
    holdPattern(1, 1, "t3");
    checkValue("t3_green_exit_quiet", {15'd0, errTiming}, 16'd0);
    holdPattern(1, 2, "t3");
    holdPattern(2, 1, "t3");
    checkValue("t3_yellow3_timing", {15'd0, errTiming}, 16'd1);
    checkValue("t3_yellow3_no_seq", {15'd0, errSeq}, 16'd0);

    // 4: AG jumps straight to BG, then BG again resyncs
    holdPattern(2, 4, "t4");
    holdPattern(3, 2, "t4");
    holdPattern(0, 5, "t4");
    applyStimulus(LT_RED, LT_GRN, "t4_jump");
    checkValue("t4_err_seq", {15'd0, errSeq}, 16'd1);
    checkValue("t4_fault", {15'd0, fault}, 16'd1);
    checkValue("t4_phase_hold", {13'd0, phase}, 16'd5);
    applyStimulus(LT_RED, LT_GRN, "t4_again");
    checkValue("t4_phase_sync", {13'd0, phase}, 16'd0);
    applyStimulus(LT_RED, LT_GRN, "t4_resync");

    // 5: illegal code on A, then both greens
    applyStimulus(3'b011, LT_RED, "t5_code");
    checkValue("t5_err_code", {15'd0, errCode}, 16'd1);
    checkValue("t5_no_seq", {15'd0, errSeq}, 16'd0);
    applyStimulus(LT_GRN, LT_GRN, "t5_conflict");
    checkValue("t5_err_conflict", {15'd0, errConflict}, 16'd1);
    holdPattern(0, 2, "t5_recover");
    checkValue("t5_fault_sticky", {15'd0, fault}, 16'd1);

    // 6: reset pulsed in the middle of BG, then resync on BG
    holdPattern(0, 3, "t6");
    holdPattern(1, 2, "t6");
    holdPattern(2, 3, "t6");
    pulseReset("t6_reset");
    checkValue("t6_fault_clear", {15'd0, fault}, 16'd0);
    checkValue("t6_phase_clear", {13'd0, phase}, 16'd0);
    applyStimulus(LT_RED, LT_GRN, "t6_resync");
    checkValue("t6_phase_bg", {13'd0, phase}, 16'd3);

    // Randomized sequences: mostly legal steps with random dwell, plus faults
    cur = 2;
    for (int s = 0; s < 300; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65) begin
        cur = (cur + 1) % 4;
        len = (cur % 2 == 0) ? int'($urandom_range(2, 10)) : int'($urandom_range(1, 3));
        holdPattern(cur, len, "rnd_legal");
      end else if (r < 75) begin
        k = int'($urandom_range(0, 4));
        len = int'($urandom_range(1, 2));
        if (k == 4) begin
          for (int i = 0; i < len; i++) applyStimulus(LT_RED, LT_RED, "rnd_allred");
        end else begin
          cur = k;
          holdPattern(cur, len, "rnd_jump");
        end
      end else if (r < 82) begin
        applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rnd_code");
      end else if (r < 88) begin
        applyStimulus(($urandom_range(0, 1) == 0) ? LT_GRN : LT_YEL,
                      ($urandom_range(0, 1) == 0) ? LT_GRN : LT_YEL, "rnd_conflict");
      end else if (r < 96) begin
        cur = 2 * int'($urandom_range(0, 1));
        holdPattern(cur, int'($urandom_range(2, 6)), "rnd_resync");
      end else begin
        pulseReset("rnd_reset");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
